// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl
//   Lookup/maintenance controller for the two-way instruction-cache tag store.
//   Drives index and write strobes of two per-way {tag,valid} RAMs (1-cycle
//   synchronous read, valid bits not reset), clears all valid bits after
//   reset, services refills and set invalidations, and turns the RAM read-back
//   into hit / hit-way / victim-way results one cycle after a lookup accept.
//
// Ports
//   clk, resetn                     clock, async active-low reset
//   req_valid/req_ready             lookup handshake
//   req_index, req_tag              lookup set index and physical tag
//   resp_valid/hit/way/victim       lookup result (cycle after accept)
//   refill_valid/index/tag/way      refill write (highest priority)
//   inv_valid, inv_index            invalidate both ways of a set
//   init_done                       valid-clear sweep finished
//   tagv_en, tag_wen, val_wen       RAM enable and per-way write strobes
//   tagv_index, tagv_wtag,
//   tagv_wvalid                     RAM index and write data
//   tagv_back0, tagv_back1          RAM read-back {tag[19:0], valid}
module icache_tag_ctrl #(
    parameter  int unsigned LINE = 128,
    localparam int unsigned IW   = $clog2(LINE)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [IW-1:0] req_index,
    input  logic [19:0]   req_tag,
    output logic          resp_valid,
    output logic          resp_hit,
    output logic          resp_way,
    output logic          resp_victim,
    input  logic          refill_valid,
    input  logic [IW-1:0] refill_index,
    input  logic [19:0]   refill_tag,
    input  logic          refill_way,
    input  logic          inv_valid,
    input  logic [IW-1:0] inv_index,
    output logic          init_done,
    output logic          tagv_en,
    output logic [1:0]    tag_wen,
    output logic [1:0]    val_wen,
    output logic [IW-1:0] tagv_index,
    output logic [19:0]   tagv_wtag,
    output logic          tagv_wvalid,
    input  logic [20:0]   tagv_back0,
    input  logic [20:0]   tagv_back1
);

    typedef enum logic {INIT, RUN} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [LINE-1:0] lru_q;

    // Lookup stage-1 register: the request whose RAM read is in flight.
    logic            s1_valid_q, s1_valid_d;
    logic [IW-1:0]   s1_index_q, s1_index_d;
    logic [19:0]     s1_tag_q,   s1_tag_d;

    logic            hit0, hit1;
    logic            refill_fire;

    // Control / RAM port: one operation per cycle, refill > invalidate > lookup.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s1_valid_d  = 1'b0;
        s1_index_d  = s1_index_q;
        s1_tag_d    = s1_tag_q;
        tagv_en     = 1'b0;
        tag_wen     = '0;
        val_wen     = '0;
        tagv_index  = cnt_q;
        tagv_wtag   = '0;
        tagv_wvalid = 1'b0;
        req_ready   = 1'b0;
        init_done   = 1'b0;
        refill_fire = 1'b0;

        case (state_q)
            INIT: begin
                tagv_en    = 1'b1;
                val_wen    = 2'b11;
                tagv_index = cnt_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == IW'(LINE - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                init_done = 1'b1;
                req_ready = !refill_valid && !inv_valid;
                if (refill_valid) begin
                    refill_fire = 1'b1;
                    tagv_en     = 1'b1;
                    tagv_index  = refill_index;
                    tag_wen     = refill_way ? 2'b10 : 2'b01;
                    val_wen     = refill_way ? 2'b10 : 2'b01;
                    tagv_wtag   = refill_tag;
                    tagv_wvalid = 1'b1;
                end else if (inv_valid) begin
                    tagv_en     = 1'b1;
                    tagv_index  = inv_index;
                    val_wen     = 2'b11;
                end else if (req_valid) begin
                    tagv_en     = 1'b1;
                    tagv_index  = req_index;
                    s1_valid_d  = 1'b1;
                    s1_index_d  = req_index;
                    s1_tag_d    = req_tag;
                end
            end
        endcase
    end

    // Compare stage: purely combinational from the RAM read-back.
    always_comb begin
        hit0        = tagv_back0[0] && (tagv_back0[20:1] == s1_tag_q);
        hit1        = tagv_back1[0] && (tagv_back1[20:1] == s1_tag_q);
        resp_valid  = s1_valid_q;
        resp_hit    = hit0 || hit1;
        resp_way    = !hit0;
        if (!tagv_back0[0]) begin
            resp_victim = 1'b0;
        end else if (!tagv_back1[0]) begin
            resp_victim = 1'b1;
        end else begin
            resp_victim = lru_q[s1_index_q];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
            s1_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_index_q <= s1_index_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    // The refill update is written last so it overrides a same-index hit update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lru_q <= '0;
        end else begin
            if (s1_valid_q && resp_hit) begin
                lru_q[s1_index_q] <= ~resp_way;
            end
            if (refill_fire) begin
                lru_q[refill_index] <= ~refill_way;
            end
        end
    end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb_icache_tag_ctrl
//   Directed bench for icache_tag_ctrl with a behavioural two-way tag RAM.
//   Lookup expectations are queued at issue time and consumed by a monitor
//   whenever resp_valid is seen.
module tb_icache_tag_ctrl;

    localparam int unsigned LINE = 128;
    localparam int unsigned IW   = 7;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid, req_ready;
    logic [IW-1:0] req_index;
    logic [19:0]   req_tag;
    logic          resp_valid, resp_hit, resp_way, resp_victim;
    logic          refill_valid;
    logic [IW-1:0] refill_index;
    logic [19:0]   refill_tag;
    logic          refill_way;
    logic          inv_valid;
    logic [IW-1:0] inv_index;
    logic          init_done, tagv_en, tagv_wvalid;
    logic [1:0]    tag_wen, val_wen;
    logic [IW-1:0] tagv_index;
    logic [19:0]   tagv_wtag;
    logic [20:0]   tagv_back0, tagv_back1;

    always #5 clk = ~clk;

    icache_tag_ctrl #(.LINE(LINE)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_victim(resp_victim),
        .refill_valid(refill_valid), .refill_index(refill_index),
        .refill_tag(refill_tag), .refill_way(refill_way),
        .inv_valid(inv_valid), .inv_index(inv_index),
        .init_done(init_done), .tagv_en(tagv_en),
        .tag_wen(tag_wen), .val_wen(val_wen),
        .tagv_index(tagv_index), .tagv_wtag(tagv_wtag),
        .tagv_wvalid(tagv_wvalid),
        .tagv_back0(tagv_back0), .tagv_back1(tagv_back1)
    );

    // Tag RAMs start full of valid entries with tag 0x55555 so that a missing
    // sweep shows up as a false hit.
    logic [20:0] mem0 [LINE] = '{default: {20'h55555, 1'b1}};
    logic [20:0] mem1 [LINE] = '{default: {20'h55555, 1'b1}};

    always @(posedge clk) begin
        if (tagv_en) begin
            tagv_back0 <= mem0[tagv_index];
            tagv_back1 <= mem1[tagv_index];
        end
        if (tag_wen[0]) mem0[tagv_index][20:1] <= tagv_wtag;
        if (tag_wen[1]) mem1[tagv_index][20:1] <= tagv_wtag;
        if (val_wen[0]) mem0[tagv_index][0]    <= tagv_wvalid;
        if (val_wen[1]) mem1[tagv_index][0]    <= tagv_wvalid;
    end

    typedef struct packed {
        logic hit;
        logic way;
        logic victim;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops one expectation per presented response.
    always @(negedge clk) begin
        if (resetn === 1'b1 && resp_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = expq.pop_front();
                check("resp_hit", {31'd0, resp_hit}, {31'd0, mon_e.hit});
                if (mon_e.hit) check("resp_way", {31'd0, resp_way}, {31'd0, mon_e.way});
                check("resp_victim", {31'd0, resp_victim}, {31'd0, mon_e.victim});
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic lookup(input logic [IW-1:0] idx, input logic [19:0] tag,
                          input logic h, input logic w, input logic v);
        int unsigned waited = 0;
        req_valid = 1'b1;
        req_index = idx;
        req_tag   = tag;
        #1;
        while (req_ready !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        if (req_ready === 1'b1) begin
            expq.push_back('{h, w, v});
            @(posedge clk); #1;
        end else begin
            check("lookup_accept_timeout", 32'd0, 32'd1);
        end
        req_valid = 1'b0;
    endtask

    task automatic refill(input logic [IW-1:0] idx, input logic way, input logic [19:0] tag);
        refill_valid = 1'b1;
        refill_index = idx;
        refill_way   = way;
        refill_tag   = tag;
        @(posedge clk); #1;
        refill_valid = 1'b0;
    endtask

    task automatic invalidate(input logic [IW-1:0] idx);
        inv_valid = 1'b1;
        inv_index = idx;
        @(posedge clk); #1;
        inv_valid = 1'b0;
    endtask

    // Checks n sweep cycles starting at index 0; begins right after reset release.
    task automatic sweep_cycles(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            check("sweep_cycle",
                  {18'd0, tagv_en, tag_wen, val_wen, tagv_index, tagv_wvalid, init_done, req_ready},
                  {18'd0, 1'b1, 2'b00, 2'b11, IW'(k), 1'b0, 1'b0, 1'b0});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_index = '0; req_tag = '0;
        refill_valid = 1'b0; refill_index = '0; refill_tag = '0; refill_way = 1'b0;
        inv_valid = 1'b0; inv_index = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {29'd0, resp_valid, init_done, req_ready}, 32'd0);

        // Sweep and init_done timing.
        resetn = 1'b1;
        sweep_cycles(LINE);
        @(negedge clk);
        check("init_done_rise", {30'd0, init_done, req_ready}, 32'd3);
        @(posedge clk); #1;

        // Sweep cleared the pre-filled valids.
        lookup(7'd5, 20'h55555, 1'b0, 1'b0, 1'b0);

        // Miss, refill, hit; then a same-index invalidate during the compare
        // cycle does not disturb that response but is seen by the next lookup.
        lookup(7'd9, 20'hABCDE, 1'b0, 1'b0, 1'b0);
        refill(7'd9, 1'b0, 20'hABCDE);
        lookup(7'd9, 20'hABCDE, 1'b1, 1'b0, 1'b1);
        lookup(7'd9, 20'hABCDE, 1'b1, 1'b0, 1'b1);
        invalidate(7'd9);
        lookup(7'd9, 20'hABCDE, 1'b0, 1'b0, 1'b0);

        // LRU on set 3.
        refill(7'd3, 1'b0, 20'h11111);
        refill(7'd3, 1'b1, 20'h22222);
        lookup(7'd3, 20'h11111, 1'b1, 1'b0, 1'b0);
        lookup(7'd3, 20'h33333, 1'b0, 1'b0, 1'b1);
        lookup(7'd3, 20'h22222, 1'b1, 1'b1, 1'b1);
        lookup(7'd3, 20'h33333, 1'b0, 1'b0, 1'b0);
        invalidate(7'd3);
        lookup(7'd3, 20'h11111, 1'b0, 1'b0, 1'b0);

        // Refill to the set of a hitting lookup in its compare cycle: refill's LRU wins.
        refill(7'd30, 1'b0, 20'h0D0D0);
        refill(7'd30, 1'b1, 20'h0E0E0);
        lookup(7'd30, 20'h0D0D0, 1'b1, 1'b0, 1'b0);
        refill(7'd30, 1'b1, 20'h0E0E0);
        lookup(7'd30, 20'h0F0F0, 1'b0, 1'b0, 1'b0);

        // Double hit reports way 0.
        refill(7'd40, 1'b0, 20'h77777);
        refill(7'd40, 1'b1, 20'h77777);
        lookup(7'd40, 20'h77777, 1'b1, 1'b0, 1'b0);

        // Priority: refill > invalidate > lookup.
        refill_valid = 1'b1; refill_index = 7'd20; refill_way = 1'b1; refill_tag = 20'h44444;
        inv_valid    = 1'b1; inv_index    = 7'd21;
        req_valid    = 1'b1; req_index    = 7'd20; req_tag    = 20'h44444;
        #1;
        check("prio_refill",
              {18'd0, tagv_en, tag_wen, val_wen, tagv_index, tagv_wvalid, req_ready},
              {18'd0, 1'b1, 2'b10, 2'b10, 7'd20, 1'b1, 1'b0});
        @(posedge clk); #1;
        refill_valid = 1'b0;
        #1;
        check("prio_inv",
              {18'd0, tagv_en, tag_wen, val_wen, tagv_index, tagv_wvalid, req_ready},
              {18'd0, 1'b1, 2'b00, 2'b11, 7'd21, 1'b0, 1'b0});
        @(posedge clk); #1;
        inv_valid = 1'b0;
        #1;
        check("prio_lookup",
              {18'd0, tagv_en, tag_wen, val_wen, tagv_index, tagv_wvalid, req_ready},
              {18'd0, 1'b1, 2'b00, 2'b00, 7'd20, 1'b0, 1'b1});
        expq.push_back('{1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("resp_drain", expq.size(), 32'd0);

        // Reset mid-sweep at index 60, then a full restart.
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        sweep_cycles(61);
        resetn = 1'b0;
        #1;
        check("midsweep_reset_outputs",
              {22'd0, resp_valid, init_done, req_ready, tagv_index},
              {22'd0, 1'b0, 1'b0, 1'b0, 7'd0});
        @(posedge clk); #1;
        resetn = 1'b1;
        sweep_cycles(LINE);
        @(negedge clk);
        check("init_done_rise_after_restart", {30'd0, init_done, req_ready}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache_tag_ctrl.md
# icache_tag_ctrl

Lookup/maintenance controller for the two-way instruction-cache tag store. It sits directly upstream of the two per-way tag+valid RAMs (1-cycle synchronous read, no reset on the valid bits). It drives their index and write strobes, consumes their 21-bit `{tag,valid}` read-back, and produces hit, hit-way and victim-way results for the fetch pipeline. It also runs the post-reset valid-clear sweep and services refill writes and index invalidations.

## Interface
- `LINE`, 128: sets per way; `IW = $clog2(LINE)`.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: lookup request.
- `req_ready` out 1: lookup accepted when `req_valid && req_ready`.
- `req_index` in IW: set index of the lookup.
- `req_tag` in 20: physical tag of the lookup.
- `resp_valid` out 1: lookup result valid (one cycle).
- `resp_hit` out 1: tag matched a valid entry.
- `resp_way` out 1: hit way.
- `resp_victim` out 1: way to refill on a miss.
- `refill_valid` in 1: write tag and set valid in one way, taking one cycle.
- `refill_index` in IW, `refill_tag` in 20, `refill_way` in 1: refill target.
- `inv_valid` in 1: clear valid in both ways of one set, taking one cycle.
- `inv_index` in IW: set index to invalidate.
- `init_done` out 1: sweep finished; block accepts traffic.
- `tagv_en` out 1: RAM access enable.
- `tag_wen` out 2: per-way tag write strobe.
- `val_wen` out 2: per-way valid write strobe.
- `tagv_index` out IW: RAM index (shared by both ways).
- `tagv_wtag` out 20: tag write data.
- `tagv_wvalid` out 1: valid write data.
- `tagv_back0`, `tagv_back1` in 21: way read-back, `{tag[19:0], valid}`.

## Operation
- States: INIT, RUN.
- Reset (async, `resetn`=0):
  - State goes to INIT and the sweep counter to 0.
  - The LRU array (LINE bits) clears to 0. The s1 register clears.
  - Outputs during reset: `resp_valid`=0, `init_done`=0, `req_ready`=0.
  - Reset asserted mid-sweep or mid-lookup aborts the operation immediately; the sweep restarts from index 0.
- INIT behaviour, per cycle:
  - Drive `tagv_index`=counter, `val_wen`=2'b11, `tagv_wvalid`=0, `tag_wen`=0, `tagv_en`=1.
  - Counter increments each cycle. After writing index LINE-1, move to RUN.
  - `refill_valid`, `inv_valid` and `req_valid` are ignored in INIT.
- RUN: one RAM operation per cycle, with fixed priority refill > invalidate > lookup.
  - Refill: `tagv_index`=`refill_index`; `tag_wen`=`val_wen`=one-hot(`refill_way`); `tagv_wtag`=`refill_tag`; `tagv_wvalid`=1. Set `lru[refill_index]` to `~refill_way`.
  - Invalidate: `tagv_index`=`inv_index`; `val_wen`=2'b11; `tagv_wvalid`=0; `tag_wen`=0. The LRU bit is unchanged.
  - Lookup:
    - `req_ready` = RUN && !`refill_valid` && !`inv_valid`.
    - On accept, drive `tagv_index`=`req_index`, no write strobes, and load s1 with `{valid=1, index, tag}`.
  - `tagv_en`=1 on any of the above, else 0.
- Compare stage, in the cycle after accept:
  - `resp_valid` = s1.valid.
  - `hitK` = `tagv_backK[0]` && `tagv_backK[20:1]`==s1.tag.
  - `resp_hit` = hit0|hit1. `resp_way` = hit0 ? 0 : 1; a double hit reports way 0.
  - `resp_victim` = !back0.valid ? 0 : !back1.valid ? 1 : `lru[s1.index]`.
  - On a hit, `lru[s1.index]` <= `~resp_way`. If a refill to the same index occurs that same cycle, the refill's LRU update wins.
  - `resp_hit`, `resp_way` and `resp_victim` are don't-care when `resp_valid`=0. Testbenches check them only when `resp_valid`=1.

## Timing
- `init_done` rises exactly LINE cycles after `resetn` deasserts (sweep cycles 0..LINE-1). `req_ready` may be 1 from that cycle.
- Lookup latency is 1 cycle: accept in cycle T gives `resp_valid` in T+1, combinational from the RAM read-back.
- Full throughput: back-to-back accepts give back-to-back responses.
- A refill or invalidate in T+1 to the same index as a lookup accepted in T does not affect the T+1 response, because the RAM returns pre-write data.
- A refill or invalidate in cycle T is visible to a lookup accepted in T+1 or later.
- `req_ready` depends combinationally on `refill_valid`/`inv_valid`. The requester holds `req_valid` and its payload until accepted.

## Test plan
- Sweep:
  - Stimulus: release reset with LINE=128.
  - Required: `val_wen`=2'b11, `tagv_wvalid`=0, indices 0..127 on consecutive cycles; `init_done`=1 at cycle 128.
  - Then a lookup of index 5 returns `resp_hit`=0 and `resp_victim`=0.
- Miss–refill–hit:
  - Stimulus: lookup idx 9 tag 0xABCDE misses; refill idx 9 way 0 tag 0xABCDE; repeat the lookup.
  - Required: `resp_hit`=1, `resp_way`=0.
- LRU:
  - Stimulus: refill idx 3 way0 tag A and way1 tag B; hit A; lookup tag C.
  - Required: `resp_victim`=1.
  - Stimulus: then hit B and lookup C again.
  - Required: `resp_victim`=0.
- Invalidate:
  - Stimulus: after both ways of idx 3 are valid, invalidate idx 3; lookup A.
  - Required: `resp_hit`=0, `resp_victim`=0.
- Priority:
  - Stimulus: `refill_valid`, `inv_valid` and `req_valid` asserted together.
  - Required: refill strobes driven and `req_ready`=0; next cycle invalidate; third cycle lookup accepted.
- Reset mid-sweep:
  - Stimulus: assert `resetn`=0 at sweep index 60, then release.
  - Required: outputs reset immediately; sweep restarts at index 0; `init_done` rises 128 cycles after the release.
